// File: rtl/fb_arbiter.sv
// Double-buffered frame-buffer arbiter: display reads the front bank,
// host writes the back bank, banks swap only on a frame_sync edge.
module fb_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 24,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    input  logic              host_frame_done,
    input  logic              frame_sync,
    output logic              swap_pending,
    output logic              front_bank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {RUN, PENDING} swap_state_t;

    swap_state_t state;
    logic [3:0]  starve_cnt;
    logic [RD_LAT:0] vpipe;
    logic        host_eligible;
    logic        starved;

    // Back bank is locked while a swap waits for the frame edge.
    assign host_eligible = host_req & ~swap_pending;
    assign starved  = host_eligible & (starve_cnt == 4'(STARVE_LIMIT));
    assign host_gnt = ~rst & host_eligible & (starved | ~disp_req);
    assign disp_gnt = ~rst & disp_req & ~starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (~host_eligible | host_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (disp_gnt) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {front_bank, disp_addr};
        end else if (host_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {~front_bank, host_addr};
            mem_wdata <= host_wdata;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // One stage for the command register plus RD_LAT stages of RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[RD_LAT-1:0], disp_gnt};
        end
    end

    assign disp_rvalid = vpipe[RD_LAT];
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            swap_pending <= 1'b0;
            front_bank   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (host_frame_done) begin
                        state        <= PENDING;
                        swap_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_sync) begin
                        state        <= RUN;
                        swap_pending <= 1'b0;
                        front_bank   <= ~front_bank;
                    end
                end
                default: begin
                    state        <= RUN;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Double-buffered frame-buffer arbiter in front of a single-port pixel RAM.
- Shares the RAM between the display scan path (reads the front bank pixel by pixel) and a host loader (writes the back bank).
- Display has priority, with a starvation guard for the host.
- Swaps front and back banks only at a frame boundary, signalled by the video controller's frame-change pulse, so no frame tears.

Parameters:
- ADDR_W, 11, pixel address width within one bank (64x32 = 2048 pixels).
- DATA_W, 24, pixel word width (RGB888).
- RD_LAT, 1, RAM read latency in cycles from a registered mem_en to valid mem_rdata (1..4).
- STARVE_LIMIT, 4, consecutive denied host-request cycles before the host gets a forced grant (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display pixel address in the front bank.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  disp_rdata valid.
- disp_rdata  out  DATA_W  read pixel.
- host_req  in  1  host write request.
- host_addr  in  ADDR_W  host pixel address in the back bank.
- host_wdata  in  DATA_W  host pixel data.
- host_gnt  out  1  host write accepted this cycle.
- host_frame_done  in  1  pulse: back bank fully written, request a swap.
- frame_sync  in  1  pulse from the video controller at the frame change.
- swap_pending  out  1  swap requested, not yet performed.
- front_bank  out  1  bank currently displayed.
- mem_en  out  1  RAM access strobe (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W+1  {bank, pixel address} (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs 0, front_bank=0, swap_pending=0, starvation counter 0, rvalid pipeline cleared.
- Reset mid-operation discards all in-flight reads: no disp_rvalid is asserted after reset.
- Grants are combinational, and at most one grant is issued per cycle.
- host_eligible = host_req & ~swap_pending. The back bank is locked while a swap is pending, so host_gnt stays 0.
- Priority in a cycle:
  - If host_eligible and starve_cnt == STARVE_LIMIT: host wins.
  - Else if disp_req: display wins.
  - Else if host_eligible: host wins.
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on cycles with host_eligible and no host grant.
  - Clears on a host grant, or when host_eligible = 0.
- Command register, loaded the cycle after a grant:
  - Display grant: mem_en=1, mem_we=0, mem_addr={front_bank, disp_addr}.
  - Host grant: mem_en=1, mem_we=1, mem_addr={~front_bank, host_addr}, mem_wdata=host_wdata.
  - No grant: mem_en=0, mem_we=0; address and data hold their previous values.
- Read return: disp_rvalid pulses exactly 1+RAM read latency (RD_LAT) cycles after the disp_gnt cycle, with disp_rdata = mem_rdata in that cycle.
  - Implement as a valid shift pipeline; back-to-back reads return back-to-back.
  - Bank select is captured at grant time, so in-flight reads are unaffected by a swap.
- Swap FSM:
  - States: RUN, PENDING.
  - RUN -> PENDING on host_frame_done; swap_pending=1 from the next cycle.
  - PENDING -> RUN on frame_sync. On that edge front_bank toggles and swap_pending clears, both in the same cycle.
  - host_frame_done in PENDING is ignored.
  - frame_sync in RUN is ignored.
  - host_frame_done and frame_sync in the same cycle while in RUN: enter PENDING, no toggle. The swap waits for the next frame_sync.
  - A grant issued in the frame_sync cycle uses the old front_bank value.
- Host writes never target the front bank, and display reads never target the back bank.

Test Plan:
1. Reset release, display reads addr 5,6,7 back-to-back, RD_LAT=1, RAM model returns addr-tagged data -> mem_addr = 0x005, 0x006, 0x007 with mem_we=0; disp_rvalid high 2 cycles after each grant, data in order; front_bank=0.
2. Host writes 0x010 with data 0xABCDEF, no display traffic -> host_gnt in the same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x810, mem_wdata=0xABCDEF.
3. disp_req held continuously, host_req held, STARVE_LIMIT=4 -> host_gnt on the 5th request cycle; disp_gnt low in that cycle only; counter restarts, and the pattern repeats every 5 cycles.
4. host_frame_done pulse, then host_req held for 10 cycles before frame_sync -> swap_pending=1, host_gnt=0 throughout; at frame_sync front_bank flips to 1 and swap_pending clears; host writes then go to bank 0 (mem_addr MSB=0).
5. host_frame_done and frame_sync in the same cycle -> swap_pending=1, front_bank unchanged; the next frame_sync toggles it. A display read granted in the toggle cycle reads bank 0.
6. rst asserted for 1 cycle, 1 cycle after a display grant with RD_LAT=2 -> no disp_rvalid ever appears; all outputs 0, front_bank=0.
